// File: rtl/hazard_ctrl_if.sv
// Bundle between hazard_ctrl and the pipeline: hazard/memory status in,
// register enables/flushes and status out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_flush;
  logic        exmem_write;
  logic        mem_err;
  logic [15:0] stall_cnt;

  // Handshake: no valid/ready pair; every control is a level that the pipeline
  // registers sample on the same rising edge as hazard_ctrl's state.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
           mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, mem_err, stall_cnt
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
           mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
           exmem_write, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, EX branch flush, data-memory
// freeze with timeout, sticky error flag and saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hif,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        mem_err_q, mem_err_nxt;
  logic [15:0] stall_cnt_q;

  logic freeze;
  logic load_use;

  assign freeze = ((state == RUN) && hif.mem_req && !hif.mem_ready) ||
                  ((state == MEMWAIT) && !hif.mem_ready);

  assign load_use = hif.ex_memread && (hif.ex_rt != 5'd0) &&
                    ((hif.ex_rt == hif.id_rs) ||
                     (hif.id_uses_rt && (hif.ex_rt == hif.id_rt)));

  // State register, including the counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_q <= mem_err_nxt;
      if (!hif.pc_write && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 8'd0;
    mem_err_nxt  = mem_err_q;
    unique case (state)
      RUN: begin
        if (freeze) state_nxt = MEMWAIT;
      end
      MEMWAIT: begin
        if (hif.mem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = ERR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output logic; branches are ordered by priority.
  always_comb begin
    hif.pc_write    = 1'b1;
    hif.ifid_write  = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_write  = 1'b1;
    hif.idex_flush  = 1'b0;
    hif.exmem_write = 1'b1;
    if (rst) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.idex_write  = 1'b0;
      hif.exmem_write = 1'b0;
      hif.ifid_flush  = 1'b1;
      hif.idex_flush  = 1'b1;
    end else if ((state == ERR) || freeze) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.idex_write  = 1'b0;
      hif.exmem_write = 1'b0;
    end else if (hif.ex_branch_taken) begin
      hif.ifid_flush = 1'b1;
      hif.idex_flush = 1'b1;
    end else if (load_use) begin
      hif.pc_write   = 1'b0;
      hif.ifid_write = 1'b0;
      hif.idex_flush = 1'b1;
    end
  end

  assign hif.mem_err   = mem_err_q;
  assign hif.stall_cnt = stall_cnt_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (WAIT_MAX=4) with a queue-based scoreboard
// and a negedge monitor.
module tb_hazard_ctrl;

  localparam logic [5:0] C_DEF = 6'b110101;
  localparam logic [5:0] C_RST = 6'b001010;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_LU  = 6'b000111;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;
  localparam int W = 25;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hif       (hif.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {hif.pc_write, hif.ifid_write, hif.ifid_flush, hif.idex_write,
            hif.idex_flush, hif.exmem_write, hif.mem_err, hif.stall_cnt,
            dbg_state};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%b err=%b stall=%h st=%0d, expected ctrl=%b err=%b stall=%h st=%0d",
                 nm, a[24:19], a[18], a[17:2], a[1:0],
                 e[24:19], e[18], e[17:2], e[1:0]);
      end
    end
  end

  // driver tasks
  task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mrd, input logic [4:0] xrt,
                        input logic br, input logic req, input logic rdy);
    rst = r;
    hif.id_rs = rs;
    hif.id_rt = rt;
    hif.id_uses_rt = urt;
    hif.ex_memread = mrd;
    hif.ex_rt = xrt;
    hif.ex_branch_taken = br;
    hif.mem_req = req;
    hif.mem_ready = rdy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tick(input string nm, input logic [5:0] c, input logic err,
                             input logic [15:0] st, input logic [1:0] s);
    exp_q.push_back({c, err, st, s});
    name_q.push_back(nm);
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    expect_tick("reset_state", C_RST, 1'b0, 16'd0, S_RUN);

    // load-use on rs, then condition clears
    set_in(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    expect_tick("lu_rs", C_LU, 1'b0, 16'd0, S_RUN);
    idle();
    expect_tick("lu_after", C_DEF, 1'b0, 16'd1, S_RUN);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_tick("lu_r0", C_DEF, 1'b0, 16'd1, S_RUN);
    set_in(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    expect_tick("lu_rt_unused", C_DEF, 1'b0, 16'd1, S_RUN);
    set_in(1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    expect_tick("lu_rt_used", C_LU, 1'b0, 16'd1, S_RUN);
    set_in(1'b0, 5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    expect_tick("no_memread", C_DEF, 1'b0, 16'd2, S_RUN);

    // branch beats load-use
    set_in(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_tick("br_over_lu", C_BR, 1'b0, 16'd2, S_RUN);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    expect_tick("mem_ready_run", C_DEF, 1'b0, 16'd2, S_RUN);
    idle();
    expect_tick("idle_run", C_DEF, 1'b0, 16'd2, S_RUN);

    // memory wait of three frozen cycles
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_tick("mw_frz0", C_FRZ, 1'b0, 16'd0, S_RUN);
    expect_tick("mw_frz1", C_FRZ, 1'b0, 16'd1, S_MW);
    expect_tick("mw_frz2", C_FRZ, 1'b0, 16'd2, S_MW);
    hif.mem_ready = 1'b1;
    expect_tick("mw_release", C_DEF, 1'b0, 16'd3, S_MW);
    idle();
    expect_tick("mw_back_run", C_DEF, 1'b0, 16'd3, S_RUN);

    // branch held across a freeze
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    expect_tick("frz_br0", C_FRZ, 1'b0, 16'd0, S_RUN);
    expect_tick("frz_br1", C_FRZ, 1'b0, 16'd1, S_MW);
    hif.mem_ready = 1'b1;
    expect_tick("frz_br_release", C_BR, 1'b0, 16'd2, S_MW);
    idle();
    expect_tick("frz_br_after", C_DEF, 1'b0, 16'd2, S_RUN);

    // load-use held across a freeze
    do_reset();
    set_in(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
    expect_tick("frz_lu0", C_FRZ, 1'b0, 16'd0, S_RUN);
    hif.mem_ready = 1'b1;
    expect_tick("frz_lu_release", C_LU, 1'b0, 16'd1, S_MW);
    idle();
    expect_tick("frz_lu_after", C_DEF, 1'b0, 16'd2, S_RUN);

    // reset in the middle of MEMWAIT
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_tick("rmw_frz0", C_FRZ, 1'b0, 16'd0, S_RUN);
    expect_tick("rmw_frz1", C_FRZ, 1'b0, 16'd1, S_MW);
    rst = 1'b1;
    expect_tick("rmw_rst", C_RST, 1'b0, 16'd2, S_MW);
    idle();
    expect_tick("rmw_after", C_DEF, 1'b0, 16'd0, S_RUN);

    // timeout: 1 RUN + 4 MEMWAIT frozen cycles, then ERR
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_tick("to_frz0", C_FRZ, 1'b0, 16'd0, S_RUN);
    expect_tick("to_frz1", C_FRZ, 1'b0, 16'd1, S_MW);
    expect_tick("to_frz2", C_FRZ, 1'b0, 16'd2, S_MW);
    expect_tick("to_frz3", C_FRZ, 1'b0, 16'd3, S_MW);
    expect_tick("to_frz4", C_FRZ, 1'b0, 16'd4, S_MW);
    expect_tick("to_err", C_FRZ, 1'b1, 16'd5, S_ERR);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    expect_tick("to_err_hold", C_FRZ, 1'b1, 16'd6, S_ERR);
    rst = 1'b1;
    expect_tick("to_err_rst", C_RST, 1'b1, 16'd7, S_ERR);
    idle();
    expect_tick("to_after_rst", C_DEF, 1'b0, 16'd0, S_RUN);

    // saturation under continuously forced load-use
    do_reset();
    set_in(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    expect_tick("sat_first", C_LU, 1'b0, 16'd0, S_RUN);
    for (int i = 0; i < 65534; i++) tick();
    expect_tick("sat_full", C_LU, 1'b0, 16'hFFFF, S_RUN);
    for (int i = 0; i < 4463; i++) tick();
    expect_tick("sat_hold", C_LU, 1'b0, 16'hFFFF, S_RUN);
    idle();
    expect_tick("sat_idle", C_DEF, 1'b0, 16'hFFFF, S_RUN);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits. It also keeps a sticky memory-timeout error and a saturating stall-cycle counter. It sits beside the pipeline registers in the top level and is the only source of their enable/flush signals.

## Interface
- WAIT_MAX, 255: maximum number of MEMWAIT cycles before timeout (1..255; the wait counter is 8 bits)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_memread  in  1  memread control held in ID/EX
- ex_rt  in  5  rt (load destination) held in ID/EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM stage is accessing data memory this cycle
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads zero (NOP)
- idex_write  out  1  ID/EX enable
- idex_flush  out  1  ID/EX loads zero controls (bubble)
- exmem_write  out  1  EX/MEM enable
- mem_err  out  1  sticky memory-timeout flag (registered)
- stall_cnt  out  16  cycles with pc_write=0 since reset, saturating

## Operation
- States: RUN, MEMWAIT, ERR. Reset state is RUN, with wait_cnt=0, stall_cnt=0 and mem_err=0.
- All controls are combinational from state and current inputs. Only state, wait_cnt, stall_cnt and mem_err are registered.
- Default (nothing pending): every *_write=1 and every *_flush=0.
- Priority, highest first: rst > ERR > memory freeze > branch flush > load-use stall.
- While rst=1: every *_write=0, ifid_flush=1, idex_flush=1.
- Memory freeze applies in RUN with mem_req=1 and mem_ready=0, and in MEMWAIT with mem_ready=0.
  - All four *_write=0 and both flushes=0.
  - In RUN, next state is MEMWAIT.
- MEMWAIT with mem_ready=1 behaves exactly like RUN for that cycle, including branch/load-use evaluation. Next state is RUN.
- Branch flush (ex_branch_taken=1, no freeze):
  - ifid_flush=1, idex_flush=1.
  - pc_write=1, so the target is loaded.
  - ifid_write=1, idex_write=1, exmem_write=1.
- Load-use stall applies when ex_memread=1, ex_rt!=0, no branch and no freeze, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
  - pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1.
- The load-use rule uses the same equations whether the state is RUN or MEMWAIT-with-ready.
- wait_cnt:
  - Cleared to 0 in RUN.
  - In MEMWAIT with mem_ready=0: if wait_cnt==WAIT_MAX-1, next state is ERR and mem_err is set to 1. Otherwise wait_cnt increments.
- ERR: every *_write=0 and every flush=0. mem_err stays 1. Only rst exits ERR.
- stall_cnt increments on every non-reset cycle in which pc_write=0, including while in ERR. It holds at 16'hFFFF and does not wrap.

## Timing
- Hazard response is zero-latency: controls apply in the same cycle the condition is present.
- Load-use stall lasts exactly one cycle. On the next edge the load moves to EX/MEM and ID/EX holds a bubble, so the condition clears.
- A freeze holds ex_branch_taken and the load-use inputs stable. They are acted on in the release cycle (MEMWAIT with mem_ready=1).
- A mem_req with mem_ready=1 in RUN causes no freeze and no state change.
- Timeout: 1 RUN detect cycle, then WAIT_MAX MEMWAIT cycles, then ERR. mem_err is visible on the cycle after the last MEMWAIT cycle.
- rst asserted in any state (including mid-MEMWAIT or ERR) returns the block to RUN with all counters and flags cleared at that edge.

## Test plan
- Load-use hazard: ex_memread=1, ex_rt=5, id_rs=5, 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1. With ex_rt=0 instead -> no stall. stall_cnt=1 after the stall.
- Branch with simultaneous load-use: ex_branch_taken=1 together with the load-use condition -> ifid_flush=1, idex_flush=1, pc_write=1 (branch wins).
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> writes=0 for 3 cycles. Release cycle has writes=1. State returns to RUN. stall_cnt=3.
- Timeout: WAIT_MAX=4, mem_req=1, mem_ready never -> 5 frozen cycles, then ERR with mem_err=1. Writes stay 0 until rst, after which mem_err=0 and stall_cnt=0.
- Freeze priority: branch taken during MEMWAIT -> no flush while mem_ready=0. Flush is asserted in the mem_ready=1 cycle.
- Saturation: 70000 consecutive load-use cycles (forced inputs) -> stall_cnt=16'hFFFF, no wrap.
